// File: rtl/poly_reduce_seq.sv
// Sequential polynomial reducer. It latches one polynomial of N signed
// W-bit coefficients and rewrites LANES coefficients per clock in place.
// Each coefficient gets reduce32, caddq, freeze or pass, chosen by the mode
// latched with start. The result comes back over a start/busy/done handshake.
module poly_reduce_seq #(
  parameter int N     = 256,
  parameter int W     = 32,
  parameter int LANES = 8,
  parameter int Q     = 8380417
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic [N*W-1:0] linear_a_in,
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] linear_a_out
);

  localparam int SLICES = N / LANES;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int AW     = (N > 1) ? $clog2(N) : 1;

  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(SLICES - 1);
  localparam logic signed [W:0]   RND_X    = (W+1)'(4194304);
  localparam logic signed [W:0]   Q_X      = (W+1)'(Q);
  localparam logic signed [W-1:0] Q_W      = W'(Q);

  localparam logic [1:0] M_REDUCE = 2'b00;
  localparam logic [1:0] M_CADDQ  = 2'b01;
  localparam logic [1:0] M_FREEZE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [1:0]           mode_q, mode_d;
  logic signed [W-1:0]  buf_q [N];
  logic signed [W-1:0]  buf_d [N];
  logic [AW-1:0]        pos;

  // r = a - round(a / 2^23) * q. The rounding sum is one bit wider so that
  // a = 2^31-1 cannot wrap; |t| <= 256 keeps t*q inside the extended word.
  function automatic logic signed [W-1:0] reduce32(input logic signed [W-1:0] a);
    logic signed [W:0] s;
    logic signed [W:0] t;
    logic signed [W:0] p;
    s = $signed({a[W-1], a}) + RND_X;
    t = s >>> 23;
    p = t * Q_X;
    s = $signed({a[W-1], a}) - p;
    return s[W-1:0];
  endfunction

  // Add q only to negative values.
  function automatic logic signed [W-1:0] caddq(input logic signed [W-1:0] a);
    return a[W-1] ? (a + Q_W) : a;
  endfunction

  function automatic logic signed [W-1:0] apply_mode(input logic [1:0] m,
                                                     input logic signed [W-1:0] a);
    case (m)
      M_REDUCE: return reduce32(a);
      M_CADDQ:  return caddq(a);
      M_FREEZE: return caddq(reduce32(a));
      default:  return a;
    endcase
  endfunction

  // Next state: latch the job in IDLE, rewrite one slice per RUN cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    buf_d   = buf_q;
    pos     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int x = 0; x < N; x++) begin
            buf_d[x] = linear_a_in[W*x +: W];
          end
          mode_d  = mode;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int l = 0; l < LANES; l++) begin
          pos        = AW'(int'(idx_q) * LANES + l);
          buf_d[pos] = apply_mode(mode_q, buf_q[pos]);
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, index, mode and coefficient buffer; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mode_q  <= '0;
      for (int x = 0; x < N; x++) begin
        buf_q[x] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      for (int x = 0; x < N; x++) begin
        buf_q[x] <= buf_d[x];
      end
    end
  end

  // The output bus mirrors the buffer at all times.
  always_comb begin
    linear_a_out = '0;
    for (int x = 0; x < N; x++) begin
      linear_a_out[W*x +: W] = buf_q[x];
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule
